// File: rtl/regfile_multiport_if.sv
// Bus interface for regfile_multiport: one write port, NUM_RD_PORTS read ports
// and the ready indication. The master drives requests; the register file is the slave.
interface regfile_multiport_if #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2
);
    logic                               i_wrEn;
    logic [ADDR_WIDTH-1:0]              i_rdAddr;
    logic [XLEN-1:0]                    i_rdData;
    logic [NUM_RD_PORTS-1:0]            i_rsEn;
    logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_rsAddr;
    logic [NUM_RD_PORTS*XLEN-1:0]       o_rsData;
    logic                               o_ready;

    modport master (
        output i_wrEn, i_rdAddr, i_rdData, i_rsEn, i_rsAddr,
        input  o_rsData, o_ready
    );

    modport slave (
        input  i_wrEn, i_rdAddr, i_rdData, i_rsEn, i_rsAddr,
        output o_rsData, o_ready
    );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-port integer register file for the decode stage.
// One write port, NUM_RD_PORTS synchronous read ports (1-cycle latency), one
// replicated RAM bank per read port, new-data read-during-write forwarding,
// per-port read hold, optional hardwired-zero x0.
// Optional feature macro: REGFILE_CLEAR_EN -- when defined, a post-reset sweep
// writes 0 to every address before o_ready rises (DEPTH cycles after reset).
// When undefined, o_ready rises one cycle after reset and contents are
// undefined until written.
module regfile_multiport #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int ZERO_REG     = 1
) (
    input logic               i_clk,
    input logic               i_rst,
    regfile_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // Per-port output source, captured on each enabled read.
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_FWD,
        SEL_RAM
    } sel_t;

    state_t state;
    state_t state_next;
    logic   ready;

    logic                  wr_to_zero;
    logic                  user_we;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [XLEN-1:0]       mem_wdata;

    logic [NUM_RD_PORTS-1:0][XLEN-1:0] rs_data;

    // Ready is a pure decode of the state register, so it changes only on a clock edge.
    assign ready       = (state == RUN);
    assign bus.o_ready = ready;
    assign bus.o_rsData = rs_data;

    // Writes to x0 are dropped when it is hardwired to zero.
    assign wr_to_zero = (ZERO_REG != 0) && (bus.i_rdAddr == '0);
    assign user_we    = !i_rst && bus.i_wrEn && ready && !wr_to_zero;

`ifdef REGFILE_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clearing;

    assign clearing = (state == CLEAR) && !i_rst;

    // Sweep address counter: restarts on reset, advances once per clear cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_cnt <= '0;
        end else if (clearing) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // The sweep owns the shared write port while clearing; user writes are blocked then anyway.
    assign mem_we    = clearing || user_we;
    assign mem_waddr = clearing ? clr_cnt : bus.i_rdAddr;
    assign mem_wdata = clearing ? '0 : bus.i_rdData;
`else
    assign mem_we    = user_we;
    assign mem_waddr = bus.i_rdAddr;
    assign mem_wdata = bus.i_rdData;
`endif

    // State register: reset always lands in CLEAR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: CLEAR exits after the last sweep write, or immediately without a sweep.
    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        case (state)
            CLEAR: begin
`ifdef REGFILE_CLEAR_EN
                if (&clr_cnt) begin
                    state_next = RUN;
                end
`else
                state_next = RUN;
`endif
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [XLEN-1:0]       bank [DEPTH];
        logic [XLEN-1:0]       ram_q;
        logic [XLEN-1:0]       fwd_q;
        sel_t                  sel_d;
        sel_t                  sel_q;
        logic                  rs_en;
        logic [ADDR_WIDTH-1:0] rs_addr;

        assign rs_en   = bus.i_rsEn[p];
        assign rs_addr = bus.i_rsAddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Replicated bank: identical write on every bank, private synchronous read.
        // NOTE: the array and its read register have no reset so the bank maps onto plain RAM;
        // zeroing is the clear sweep's job, and sel_q masks ram_q until a real read lands.
        always_ff @(posedge i_clk) begin
            if (mem_we) begin
                bank[mem_waddr] <= mem_wdata;
            end
            if (rs_en) begin
                ram_q <= bank[rs_addr];
            end
        end

        // Source priority for this read: not ready, then hardwired zero, then forward, then RAM.
        always_comb begin
            sel_d = SEL_RAM;
            if (!ready) begin
                sel_d = SEL_ZERO;
            end else if ((ZERO_REG != 0) && (rs_addr == '0)) begin
                sel_d = SEL_ZERO;
            end else if (bus.i_wrEn && (rs_addr == bus.i_rdAddr)) begin
                sel_d = SEL_FWD;
            end
        end

        // Capture source and forward data on enabled reads; hold otherwise (pipeline stall).
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sel_q <= SEL_ZERO;
                fwd_q <= '0;
            end else if (rs_en) begin
                sel_q <= sel_d;
                fwd_q <= bus.i_rdData;
            end
        end

        assign rs_data[p] = (sel_q == SEL_FWD) ? fwd_q :
                            (sel_q == SEL_RAM) ? ram_q : '0;
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a directed vector table, a mid-operation
// reset sequence, and randomized traffic, all checked against an array-based model.
// Works with or without REGFILE_CLEAR_EN defined.
module tb_regfile_multiport;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NP   = 2;
    localparam int ZREG = 1;
    localparam int NREG = 2 ** AW;

`ifdef REGFILE_CLEAR_EN
    localparam int          LAT    = NREG;
    localparam logic [31:0] EXP_X9 = 32'h0;
`else
    localparam int          LAT    = 1;
    localparam logic [31:0] EXP_X9 = 32'h0000_9999;
`endif
    localparam int PRE_K = (LAT > 10) ? 10 : 0;

    logic i_clk;
    logic i_rst;

    regfile_multiport_if #(.XLEN(XLEN), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP)) bus ();

    regfile_multiport #(
        .XLEN(XLEN), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NP), .ZERO_REG(ZREG)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents plus what each port should show.
    logic [31:0] m_regs  [NREG];
    bit          m_known [NREG];
    logic [31:0] m_out   [NP];
    bit          m_okn   [NP];
    bit          m_ready;
    int          rel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit wr, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        bus.i_wrEn   = wr;
        bus.i_rdAddr = wa;
        bus.i_rdData = wd;
        bus.i_rsEn   = en;
        bus.i_rsAddr = {a1, a0};
    endtask

    function automatic logic [31:0] port_out(input int p);
        return bus.o_rsData[p*XLEN +: XLEN];
    endfunction

    // One clock: predict from the spec rules, commit, step the edge, compare.
    task automatic cycle();
        logic [4:0] a;
        for (int p = 0; p < NP; p++) begin
            a = bus.i_rsAddr[p*AW +: AW];
            if (i_rst) begin
                m_out[p] = '0;
                m_okn[p] = 1'b1;
            end else if (bus.i_rsEn[p]) begin
                if (!m_ready || (ZREG != 0 && a == 0)) begin
                    m_out[p] = '0;
                    m_okn[p] = 1'b1;
                end else if (bus.i_wrEn && a == bus.i_rdAddr) begin
                    m_out[p] = bus.i_rdData;
                    m_okn[p] = 1'b1;
                end else begin
                    m_out[p] = m_regs[a];
                    m_okn[p] = m_known[a];
                end
            end
        end
        if (!i_rst && m_ready && bus.i_wrEn && !(ZREG != 0 && bus.i_rdAddr == 0)) begin
            m_regs[bus.i_rdAddr]  = bus.i_rdData;
            m_known[bus.i_rdAddr] = 1'b1;
        end
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            rel     = 0;
            m_ready = 1'b0;
        end else begin
            rel++;
            if (!m_ready && rel >= LAT) begin
                m_ready = 1'b1;
`ifdef REGFILE_CLEAR_EN
                for (int r = 0; r < NREG; r++) begin
                    m_regs[r]  = '0;
                    m_known[r] = 1'b1;
                end
`endif
            end
        end
        check("model_ready", {31'b0, bus.o_ready}, {31'b0, m_ready});
        for (int p = 0; p < NP; p++) begin
            if (m_okn[p]) begin
                check($sformatf("model_port%0d", p), port_out(p), m_out[p]);
            end
        end
    endtask

    // Release reset and count cycles until ready, bounded.
    task automatic await_ready(input string name, input bit keep_writing);
        int n;
        n = 0;
        i_rst = 1'b0;
        while (!bus.o_ready && n < 200) begin
            if (keep_writing) drive(1'b1, 5'd9, 32'h0000_0BAD, 2'b00, 5'd0, 5'd0);
            cycle();
            n++;
        end
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
        check(name, n, LAT);
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [1:0]  chk;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] z_or_ones;
        z_or_ones = (ZREG != 0) ? 32'h0 : 32'hFFFF_FFFF;

        tbl[0]  = '{1'b1, 5'd7, 32'h0000_0001, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 5'd8, 32'h0000_00AA, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 5'd3, 32'h0000_0055, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0, 2'b00, 32'h0, 32'h0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,         2'b11, 5'd5, 5'd5, 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 5'd7, 32'h1234_5678, 2'b11, 5'd8, 5'd7, 2'b11, 32'h0000_00AA, 32'h1234_5678};
        tbl[6]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 2'b01, 5'd0, 5'd7, 2'b11, z_or_ones, 32'h1234_5678};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,         2'b01, 5'd0, 5'd7, 2'b11, z_or_ones, 32'h1234_5678};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,         2'b11, 5'd3, 5'd3, 2'b11, 32'h0000_0055, 32'h0000_0055};
        tbl[9]  = '{1'b1, 5'd3, 32'h0000_0066, 2'b10, 5'd3, 5'd7, 2'b11, 32'h0000_0055, 32'h1234_5678};
        tbl[10] = '{1'b0, 5'd0, 32'h0,         2'b01, 5'd3, 5'd7, 2'b11, 32'h0000_0066, 32'h1234_5678};
        tbl[11] = '{1'b1, 5'd3, 32'h0000_0077, 2'b11, 5'd3, 5'd3, 2'b11, 32'h0000_0077, 32'h0000_0077};
        tbl[12] = '{1'b1, 5'd3, 32'h0000_0088, 2'b00, 5'd3, 5'd3, 2'b11, 32'h0000_0077, 32'h0000_0077};
        tbl[13] = '{1'b0, 5'd0, 32'h0,         2'b11, 5'd3, 5'd0, 2'b11, 32'h0000_0088, z_or_ones};

        for (int r = 0; r < NREG; r++) begin
            m_regs[r]  = '0;
            m_known[r] = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            m_out[p] = '0;
            m_okn[p] = 1'b0;
        end
        m_ready = 1'b0;
        rel     = 0;

        // Reset state.
        i_rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) cycle();
        check("reset_ready", {31'b0, bus.o_ready}, 32'h0);
        check("reset_port0", port_out(0), 32'h0);
        check("reset_port1", port_out(1), 32'h0);

        // Release: ready latency depends on whether the clear sweep exists.
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
        await_ready("ready_latency", 1'b0);

        // Read every register on both ports; after a sweep all read zero.
        for (int i = 1; i < NREG; i++) begin
            drive(1'b0, 5'd0, 32'h0, 2'b11, 5'(i), 5'(NREG - i));
            cycle();
        end

        // Directed vectors.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].en, tbl[i].a0, tbl[i].a1);
            cycle();
            if (tbl[i].chk[0]) check($sformatf("vec%0d_port0", i), port_out(0), tbl[i].e0);
            if (tbl[i].chk[1]) check($sformatf("vec%0d_port1", i), port_out(1), tbl[i].e1);
        end

        // Mid-operation reset: pending writes while not ready must vanish.
        drive(1'b1, 5'd9, 32'h0000_9999, 2'b00, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd3);
        cycle();
        check("pre_rst_x9", port_out(0), 32'h0000_9999);
        i_rst = 1'b1;
        drive(1'b1, 5'd9, 32'h0000_0BAD, 2'b00, 5'd0, 5'd0);
        cycle();
        check("midrst_ready", {31'b0, bus.o_ready}, 32'h0);
        check("midrst_port0", port_out(0), 32'h0);
        check("midrst_port1", port_out(1), 32'h0);
        cycle();
        i_rst = 1'b0;
        for (int i = 0; i < PRE_K; i++) begin
            drive(1'b1, 5'd9, 32'h0000_0BAD, 2'b00, 5'd0, 5'd0);
            cycle();
        end
        i_rst = 1'b1;
        drive(1'b1, 5'd9, 32'h0000_0BAD, 2'b01, 5'd9, 5'd0);
        cycle();
        check("rerst_ready", {31'b0, bus.o_ready}, 32'h0);
        await_ready("restart_latency", 1'b1);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd9);
        cycle();
        check("post_rst_x9_port0", port_out(0), EXP_X9);
        check("post_rst_x9_port1", port_out(1), EXP_X9);

        // Randomized traffic concentrated on a few addresses to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa, a0, a1;
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, NREG - 1)) : 5'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, NREG - 1)) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), wa, $urandom(), 2'($urandom_range(0, 3)), a0, a1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
